cc1200_spi_master: RTL and testbench



---
 rtl/cc1200_spi_master.sv | 235 +++++++++++++++++++++++
 tb/tb_cc1200_spi_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc1200_spi_master.sv
// SPI master for one CC1200 port: turns one register command (strobe, normal
// or extended read/write) into a single CS_n-framed transfer and returns the
// chip status byte plus the last received byte.
module cc1200_spi_master #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned CSN_SETUP   = 2,
    parameter int unsigned CSN_HOLD    = 2,
    parameter int unsigned CSN_GAP     = 4,
    parameter int unsigned RDY_TIMEOUT = 1024
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic       cmd_ext,
    input  logic       cmd_strobe,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_status,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       SCLK,
    output logic       CS_n,
    output logic       MOSI,
    input  logic       MISO
);

    // One shared phase counter, wide enough for the longest wait
    localparam int unsigned CNT_W =
        $clog2(RDY_TIMEOUT + CLK_DIV + CSN_SETUP + CSN_HOLD + CSN_GAP + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CSN_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CSN_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CSN_GAP - 1);
    localparam logic [CNT_W-1:0] RDY_LAST   = CNT_W'(RDY_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [4:0]       bit_cnt, bit_cnt_nx;
    logic [4:0]       frame_bits, frame_bits_nx;
    logic [23:0]      tx_sh, tx_sh_nx;
    logic [7:0]       rx_sh, rx_sh_nx;
    logic [7:0]       status_cap, status_cap_nx;
    logic [7:0]       data_byte;
    logic             cmd_ready_nx, rsp_valid_nx, rsp_timeout_nx;
    logic [7:0]       rsp_status_nx, rsp_rdata_nx;
    logic             sclk_nx, cs_n_nx, mosi_nx;

    // State register
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        bit_cnt_nx     = bit_cnt;
        frame_bits_nx  = frame_bits;
        tx_sh_nx       = tx_sh;
        rx_sh_nx       = rx_sh;
        status_cap_nx  = status_cap;
        cmd_ready_nx   = cmd_ready;
        rsp_valid_nx   = 1'b0;
        rsp_timeout_nx = rsp_timeout;
        rsp_status_nx  = rsp_status;
        rsp_rdata_nx   = rsp_rdata;
        sclk_nx        = SCLK;
        cs_n_nx        = CS_n;
        mosi_nx        = MOSI;
        data_byte      = cmd_rw ? 8'h00 : cmd_wdata;

        case (state)
            S_IDLE: begin
                cs_n_nx = 1'b1;
                sclk_nx = 1'b0;
                mosi_nx = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    state_nx     = S_WAIT;
                    cmd_ready_nx = 1'b0;
                    cs_n_nx      = 1'b0;
                    cnt_nx       = '0;
                    bit_cnt_nx   = '0;
                    if (cmd_strobe) begin
                        tx_sh_nx      = {2'b00, cmd_addr[5:0], 16'h0000};
                        frame_bits_nx = 5'd8;
                    end else if (cmd_ext) begin
                        tx_sh_nx      = {cmd_rw, 1'b0, 6'h2F, cmd_addr, data_byte};
                        frame_bits_nx = 5'd24;
                    end else begin
                        tx_sh_nx      = {cmd_rw, 1'b0, cmd_addr[5:0], data_byte, 8'h00};
                        frame_bits_nx = 5'd16;
                    end
                end
            end

            // CS_n low, waiting for CHIP_RDYn (MISO low)
            S_WAIT: begin
                if (!MISO) begin
                    state_nx = S_SETUP;
                    cnt_nx   = '0;
                    mosi_nx  = tx_sh[23];
                end else if (cnt == RDY_LAST) begin
                    state_nx       = S_GAP;
                    cnt_nx         = '0;
                    cs_n_nx        = 1'b1;
                    rsp_valid_nx   = 1'b1;
                    rsp_timeout_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nx = S_SHIFT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

            // Low half then high half per bit; sample on rise, shift on fall
            S_SHIFT: begin
                if (cnt != DIV_LAST) begin
                    cnt_nx = cnt + CNT_W'(1);
                end else if (!SCLK) begin
                    cnt_nx   = '0;
                    sclk_nx  = 1'b1;
                    rx_sh_nx = {rx_sh[6:0], MISO};
                    if (bit_cnt == 5'd7) begin
                        status_cap_nx = {rx_sh[6:0], MISO};
                    end
                end else begin
                    cnt_nx  = '0;
                    sclk_nx = 1'b0;
                    if (bit_cnt == frame_bits - 5'd1) begin
                        state_nx = S_HOLD;
                        mosi_nx  = 1'b0;
                    end else begin
                        bit_cnt_nx = bit_cnt + 5'd1;
                        tx_sh_nx   = {tx_sh[22:0], 1'b0};
                        mosi_nx    = tx_sh[22];
                    end
                end
            end

            S_HOLD: begin
                mosi_nx = 1'b0;
                if (cnt == HOLD_LAST) begin
                    state_nx       = S_GAP;
                    cnt_nx         = '0;
                    cs_n_nx        = 1'b1;
                    rsp_valid_nx   = 1'b1;
                    rsp_timeout_nx = 1'b0;
                    rsp_status_nx  = status_cap;
                    rsp_rdata_nx   = rx_sh;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

            // Enforced CS_n-high time between frames
            S_GAP: begin
                cs_n_nx = 1'b1;
                if (cnt == GAP_LAST) begin
                    state_nx     = S_IDLE;
                    cnt_nx       = '0;
                    cmd_ready_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nx     = S_IDLE;
                cnt_nx       = '0;
                cmd_ready_nx = 1'b1;
                cs_n_nx      = 1'b1;
                sclk_nx      = 1'b0;
                mosi_nx      = 1'b0;
            end
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt         <= '0;
            bit_cnt     <= '0;
            frame_bits  <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            status_cap  <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_status  <= '0;
            rsp_rdata   <= '0;
            SCLK        <= 1'b0;
            CS_n        <= 1'b1;
            MOSI        <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            bit_cnt     <= bit_cnt_nx;
            frame_bits  <= frame_bits_nx;
            tx_sh       <= tx_sh_nx;
            rx_sh       <= rx_sh_nx;
            status_cap  <= status_cap_nx;
            cmd_ready   <= cmd_ready_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_timeout <= rsp_timeout_nx;
            rsp_status  <= rsp_status_nx;
            rsp_rdata   <= rsp_rdata_nx;
            SCLK        <= sclk_nx;
            CS_n        <= cs_n_nx;
            MOSI        <= mosi_nx;
        end
    end

endmodule

// File: tb/tb_cc1200_spi_master.sv
// Scoreboard bench for cc1200_spi_master: stimulus pushes expected frames,
// a negedge monitor models the CC1200 MISO side, observes the SPI pins and
// checks each response.
module tb_cc1200_spi_master;

    localparam int CLK_DIV     = 2;
    localparam int CSN_SETUP   = 2;
    localparam int CSN_HOLD    = 2;
    localparam int CSN_GAP     = 4;
    localparam int RDY_TIMEOUT = 16;

    typedef struct packed {
        logic [23:0] miso_pat;
        logic        miso_stuck;
        logic [23:0] exp_mosi;
        logic [5:0]  exp_rises;
        logic [7:0]  exp_status;
        logic [7:0]  exp_rdata;
        logic        exp_timeout;
        logic [7:0]  exp_low;
    } ent_t;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0, cmd_ext = 1'b0, cmd_strobe = 1'b0;
    logic [7:0] cmd_addr = 8'h00, cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_status, rsp_rdata;
    logic       rsp_timeout;
    logic       SCLK, CS_n, MOSI;
    logic       MISO;

    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done = 1'b0;
    int   rises = 0;

    cc1200_spi_master #(
        .CLK_DIV(CLK_DIV), .CSN_SETUP(CSN_SETUP), .CSN_HOLD(CSN_HOLD),
        .CSN_GAP(CSN_GAP), .RDY_TIMEOUT(RDY_TIMEOUT)
    ) dut (
        .sysclk(sysclk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_ext(cmd_ext), .cmd_strobe(cmd_strobe),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .SCLK(SCLK), .CS_n(CS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // CS_n low time of a frame whose chip is ready at once (one WAIT cycle)
    function automatic logic [7:0] low_len(input int n);
        return 8'(1 + CSN_SETUP + n * 2 * CLK_DIV + CSN_HOLD);
    endfunction

    function automatic ent_t mk_ready(input logic [23:0] pat, input logic [23:0] mosi,
                                      input int n, input logic [7:0] st,
                                      input logic [7:0] rd);
        ent_t e;
        e.miso_pat    = pat;
        e.miso_stuck  = 1'b0;
        e.exp_mosi    = mosi;
        e.exp_rises   = 6'(n);
        e.exp_status  = st;
        e.exp_rdata   = rd;
        e.exp_timeout = 1'b0;
        e.exp_low     = low_len(n);
        return e;
    endfunction

    function automatic ent_t mk_timeout(input logic [7:0] st, input logic [7:0] rd);
        ent_t e;
        e.miso_pat    = 24'h0;
        e.miso_stuck  = 1'b1;
        e.exp_mosi    = 24'h0;
        e.exp_rises   = 6'd0;
        e.exp_status  = st;
        e.exp_rdata   = rd;
        e.exp_timeout = 1'b1;
        e.exp_low     = 8'(RDY_TIMEOUT);
        return e;
    endfunction

    task automatic drive_cmd(input logic rw, input logic ext, input logic strobe,
                             input logic [7:0] addr, input logic [7:0] wdata,
                             input bit hold);
        int budget = 2000;
        cmd_rw = rw; cmd_ext = ext; cmd_strobe = strobe;
        cmd_addr = addr; cmd_wdata = wdata;
        cmd_valid = 1'b1;
        while (!cmd_ready) begin
            @(posedge sysclk); #1;
            budget--;
            if (budget == 0) begin
                $display("FAIL cmd_ready_wait: got 0x0, required 0x1");
                $fatal(1, "cmd_ready never returned");
            end
        end
        @(posedge sysclk); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 3000;
        while (exp_q.size() != 0) begin
            @(posedge sysclk); #1;
            budget--;
            if (budget == 0) begin
                $display("FAIL rsp_wait: got 0x0, required 0x1");
                $fatal(1, "response never arrived");
            end
        end
    endtask

    // Stimulus
    initial begin
        int budget;
        repeat (4) @(posedge sysclk);
        #1 rst = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;

        // Normal write 0x01 / 0xA5
        exp_q.push_back(mk_ready(24'h0F5500, 24'h0001A5, 16, 8'h0F, 8'h55));
        drive_cmd(1'b0, 1'b0, 1'b0, 8'h01, 8'hA5, 1'b0);
        wait_done();

        // Extended read 0x8F, wdata ignored on read
        exp_q.push_back(mk_ready(24'h0F003C, 24'hAF8F00, 24, 8'h0F, 8'h3C));
        drive_cmd(1'b1, 1'b1, 1'b0, 8'h8F, 8'h77, 1'b0);
        wait_done();

        // Extended write 0x0A / 0x12
        exp_q.push_back(mk_ready(24'h0FAA55, 24'h2F0A12, 24, 8'h0F, 8'h55));
        drive_cmd(1'b0, 1'b1, 1'b0, 8'h0A, 8'h12, 1'b0);
        wait_done();

        // Normal write with addr[7:6] set (ignored)
        exp_q.push_back(mk_ready(24'h000000, 24'h0002FF, 16, 8'h00, 8'h00));
        drive_cmd(1'b0, 1'b0, 1'b0, 8'hC2, 8'hFF, 1'b0);
        wait_done();

        // Strobe SIDLE with rw/ext/wdata set (ignored)
        exp_q.push_back(mk_ready(24'h1F0000, 24'h000036, 8, 8'h1F, 8'h1F));
        drive_cmd(1'b1, 1'b1, 1'b1, 8'h36, 8'hAA, 1'b0);
        wait_done();

        // MISO stuck high: timeout, status/rdata keep the strobe's values
        exp_q.push_back(mk_timeout(8'h1F, 8'h1F));
        drive_cmd(1'b1, 1'b0, 1'b0, 8'h0A, 8'h00, 1'b0);
        wait_done();

        // Reset in the middle of a normal write; no response expected
        drive_cmd(1'b0, 1'b0, 1'b0, 8'h01, 8'hA5, 1'b0);
        budget = 500;
        while (rises < 9) begin
            @(posedge sysclk); #1;
            budget--;
            if (budget == 0) begin
                $display("FAIL abort_rise_wait: got 0x%0h, required 0x9", rises);
                $fatal(1, "SCLK never reached bit 9");
            end
        end
        rst = 1'b1;
        @(posedge sysclk); #1;
        rst = 1'b0;
        repeat (10) @(posedge sysclk);
        #1;

        // Normal read 0x25 after the abort
        exp_q.push_back(mk_ready(24'h2F8100, 24'h00A500, 16, 8'h2F, 8'h81));
        drive_cmd(1'b1, 1'b0, 1'b0, 8'h25, 8'h00, 1'b0);
        wait_done();

        // Back-to-back: cmd_valid held high across both commands
        exp_q.push_back(mk_ready(24'h0FC300, 24'h003F5A, 16, 8'h0F, 8'hC3));
        exp_q.push_back(mk_ready(24'h7E0000, 24'h00003D, 8, 8'h7E, 8'h7E));
        drive_cmd(1'b0, 1'b0, 1'b0, 8'h3F, 8'h5A, 1'b1);
        drive_cmd(1'b1, 1'b1, 1'b1, 8'hFD, 8'h00, 1'b0);
        wait_done();

        repeat (20) @(posedge sysclk);
        #1 done = 1'b1;
    end

    // Monitor: CC1200 MISO model, pin observer and scoreboard checks
    initial begin
        ent_t        e;
        ent_t        cur;
        bit          rst_pend = 1'b0;
        bit          seen_frame = 1'b0;
        bit          hi_bad = 1'b0;
        logic        cs_prev = 1'b1;
        logic        sclk_prev = 1'b0;
        logic [23:0] mosi_obs = 24'h0;
        int          low_cnt = 0;
        int          hi_cnt = 0;
        int          idx = 0;
        int          high_run = 0;

        MISO = 1'b1;
        forever begin
            @(negedge sysclk);

            if (rst_pend) begin
                check("rst_cmd_ready",   cmd_ready == 1'b1,   32'(cmd_ready),   32'h1);
                check("rst_rsp_valid",   rsp_valid == 1'b0,   32'(rsp_valid),   32'h0);
                check("rst_rsp_status",  rsp_status == 8'h00, 32'(rsp_status),  32'h0);
                check("rst_rsp_rdata",   rsp_rdata == 8'h00,  32'(rsp_rdata),   32'h0);
                check("rst_rsp_timeout", rsp_timeout == 1'b0, 32'(rsp_timeout), 32'h0);
                check("rst_sclk",        SCLK == 1'b0,        32'(SCLK),        32'h0);
                check("rst_cs_n",        CS_n == 1'b1,        32'(CS_n),        32'h1);
                check("rst_mosi",        MOSI == 1'b0,        32'(MOSI),        32'h0);
            end
            rst_pend = rst;

            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1'b0, 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_status",  rsp_status == e.exp_status,   32'(rsp_status),  32'(e.exp_status));
                    check("rsp_rdata",   rsp_rdata == e.exp_rdata,     32'(rsp_rdata),   32'(e.exp_rdata));
                    check("rsp_timeout", rsp_timeout == e.exp_timeout, 32'(rsp_timeout), 32'(e.exp_timeout));
                    check("mosi_frame",  mosi_obs == e.exp_mosi,       32'(mosi_obs),    32'(e.exp_mosi));
                    check("sclk_rises",  rises == int'(e.exp_rises),   32'(rises),       32'(e.exp_rises));
                    check("cs_low_len",  low_cnt == int'(e.exp_low),   32'(low_cnt),     32'(e.exp_low));
                    check("sclk_high_width", !hi_bad,                  32'(hi_bad),      32'h0);
                    check("busy_cmd_ready",  cmd_ready == 1'b0,        32'(cmd_ready),   32'h0);
                end
            end

            if (cs_prev && !CS_n) begin
                if (seen_frame)
                    check("cs_gap", high_run >= CSN_GAP + 1, 32'(high_run), 32'(CSN_GAP + 1));
                seen_frame = 1'b1;
                rises    = 0;
                low_cnt  = 0;
                hi_cnt   = 0;
                hi_bad   = 1'b0;
                idx      = 0;
                mosi_obs = 24'h0;
                high_run = 0;
            end
            if (CS_n) high_run++;
            else      low_cnt++;
            if (!sclk_prev && SCLK) begin
                rises++;
                mosi_obs = {mosi_obs[22:0], MOSI};
            end
            if (SCLK) hi_cnt++;
            if (sclk_prev && !SCLK) begin
                if (hi_cnt != CLK_DIV) hi_bad = 1'b1;
                hi_cnt = 0;
                idx++;
            end
            cs_prev   = CS_n;
            sclk_prev = SCLK;

            // Slave presents the next bit after each SCLK fall
            if (CS_n) begin
                MISO = 1'b1;
            end else if (exp_q.size() != 0) begin
                cur = exp_q[0];
                if (cur.miso_stuck)  MISO = 1'b1;
                else if (idx < 24)   MISO = cur.miso_pat[5'(23 - idx)];
                else                 MISO = 1'b0;
            end else begin
                MISO = 1'b0;
            end

            if (done) begin
                check("queue_empty", exp_q.size() == 0, 32'(exp_q.size()), 32'h0);
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $finish;
            end
        end
    end

endmodule
